// File: rtl/multiplicador_shift_add.sv
// Sequential unsigned shift-and-add multiplier with START/DONE handshake.
// PP accumulates MD for each set bit of MR; exits early once MR is exhausted.
module multiplicador_shift_add #(
    parameter int WIDTH     = 16,
    parameter int DONE_HOLD = 31
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   PP,
    output logic                 DONE,
    output logic                 BUSY
);

    localparam int CW = $clog2(DONE_HOLD + 1);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_CHECK = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_END1  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   pp_q, pp_d;
    logic [2*WIDTH-1:0]   md_q, md_d;
    logic [WIDTH-1:0]     mr_q, mr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_START;
            pp_q    <= '0;
            md_q    <= '0;
            mr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pp_q    <= pp_d;
            md_q    <= md_d;
            mr_q    <= mr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pp_d    = pp_q;
        md_d    = md_q;
        mr_d    = mr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_START: begin
                if (START) begin
                    md_d    = {{WIDTH{1'b0}}, A};
                    mr_d    = B;
                    pp_d    = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mr_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_END1;
                end else if (mr_q[0]) begin
                    state_d = S_ADD;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ADD: begin
                pp_d    = pp_q + md_q;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                md_d    = md_q << 1;
                mr_d    = mr_q >> 1;
                state_d = S_CHECK;
            end
            S_END1: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DONE_HOLD - 1)) begin
                    state_d = S_START;
                end
            end
            default: state_d = S_START;
        endcase
    end

    assign PP   = pp_q;
    assign DONE = (state_q == S_END1);
    assign BUSY = (state_q == S_CHECK) ||
                  (state_q == S_ADD)   ||
                  (state_q == S_SHIFT);

endmodule

// File: tb/tb_multiplicador_shift_add.sv
// Directed bench for the shift-add multiplier with a cycle-level
// behavioural model of the handshake and a per-cycle compare process.
module tb_multiplicador_shift_add;

    localparam int W  = 16;
    localparam int DH = 31;

    logic            CLK   = 1'b0;
    logic            RST_N = 1'b0;
    logic            START = 1'b0;
    logic [W-1:0]    A     = '0;
    logic [W-1:0]    B     = '0;
    logic [2*W-1:0]  PP;
    logic            DONE;
    logic            BUSY;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    multiplicador_shift_add #(.WIDTH(W), .DONE_HOLD(DH)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .START(START),
        .A    (A),
        .B    (B),
        .PP   (PP),
        .DONE (DONE),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    // Busy cycles: one check per examined bit pair plus the final zero check.
    function automatic int busy_len(input logic [W-1:0] b);
        int s = 1;
        for (int i = 0; i < W; i++) begin
            if ((b >> i) != 0) s += b[i] ? 3 : 2;
        end
        return s;
    endfunction

    // Model: 0=idle, 1=busy, 2=done
    int              m_mode = 0;
    int              m_rem  = 0;
    logic [2*W-1:0]  m_prod = '0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_mode = 0;
            m_rem  = 0;
            m_prod = '0;
        end else begin
            case (m_mode)
                0: if (START) begin
                    m_mode = 1;
                    m_rem  = busy_len(B);
                    m_prod = (2*W)'(A) * (2*W)'(B);
                end
                1: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_mode = 2;
                        m_rem  = DH;
                    end
                end
                default: begin
                    m_rem--;
                    if (m_rem == 0) m_mode = 0;
                end
            endcase
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("cmp_busy", 64'(BUSY), 64'(m_mode == 1));
            check("cmp_done", 64'(DONE), 64'(m_mode == 2));
            if (m_mode != 1) check("cmp_pp", 64'(PP), 64'(m_prod));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_pp, input int exp_busy,
                          input bit chg, input bit noise, input string nm);
        int n = 0;
        int d = 0;
        A = a;
        B = b;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        if (chg) begin
            A = 1;
            B = 1;
        end
        while (BUSY && n < 200) begin
            START = noise && (n == 2);
            n++;
            @(negedge CLK);
        end
        START = 1'b0;
        check({nm, "_latency"}, 64'(n), 64'(exp_busy));
        check({nm, "_pp"}, 64'(PP), 64'(exp_pp));
        while (DONE && d < 100) begin
            START = noise && (d == 5);
            d++;
            @(negedge CLK);
        end
        START = 1'b0;
        check({nm, "_donelen"}, 64'(d), 64'(DH));
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_pp", 64'(PP), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        RST_N = 1'b1;
        chk_en = 1'b1;
        @(negedge CLK);

        run_op(16'h1234, 16'h0000, 32'd0,          1,  0, 0, "b_zero");
        run_op(16'd3,    16'd5,    32'd15,         9,  0, 0, "3x5");
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001,   49, 0, 0, "max");
        run_op(16'd7,    16'd9,    32'd63,         11, 1, 0, "latch");
        run_op(16'd3,    16'd5,    32'd15,         9,  0, 1, "noise");

        A = 16'hFFFF;
        B = 16'h8001;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("arst_pp", 64'(PP), 64'd0);
        check("arst_done", 64'(DONE), 64'd0);
        check("arst_busy", 64'(BUSY), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        run_op(16'hFFFF, 16'h8001, 32'h80007FFF, 35, 0, 0, "after_rst");

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
